// File: rtl/led_fade_engine.sv
// Eight-channel LED fade engine: per-frame stepping of cur[] toward target[] with registered PWM levels.
// Define FADE_EXP_CURVE_EN to map levels through an exponential brightness curve; default is linear.
module led_fade_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_ch,
    input  logic [7:0]  wr_data,
    input  logic [3:0]  rate,
    input  logic        frame_tick,
    output logic [63:0] pwm_val,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  target_q [8];
    logic [7:0]  target_d [8];
    logic [7:0]  cur_q [8];
    logic [7:0]  cur_d [8];
    logic [63:0] pwm_q, pwm_d;
    logic [3:0]  presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic        overrun_q, overrun_d;
    logic        step;

`ifdef FADE_EXP_CURVE_EN
    function automatic logic [7:0] fade_map(input logic [7:0] v);
        logic [12:0] s;
        s = {7'd0, 1'b1, v[4:0]} << v[7:5];
        fade_map = (v == 8'd0) ? 8'd0 : s[12:5];
    endfunction
`else
    function automatic logic [7:0] fade_map(input logic [7:0] v);
        fade_map = v;
    endfunction
`endif

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cur_d     = cur_q;
        presc_d   = presc_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        step      = 1'b0;

        // ">=" lets a rate reduction below the current prescaler fire immediately
        if (frame_tick && (rate != 4'd0)) begin
            if (presc_q >= rate - 4'd1) begin
                step    = 1'b1;
                presc_d = '0;
            end else begin
                presc_d = presc_q + 4'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (step) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (step) overrun_d = 1'b1;
                if (cur_q[idx_q] < target_q[idx_q])
                    cur_d[idx_q] = cur_q[idx_q] + 8'd1;
                else if (cur_q[idx_q] > target_q[idx_q])
                    cur_d[idx_q] = cur_q[idx_q] - 8'd1;
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rate == 4'd0) begin
            for (int unsigned i = 0; i < 8; i++) cur_d[i] = target_q[i];
        end

        // Written after the scan step so a same-cycle write only affects the next pass
        if (wr_en) target_d[wr_ch] = wr_data;

        pwm_d = '0;
        for (int unsigned i = 0; i < 8; i++) pwm_d[8*i +: 8] = fade_map(cur_q[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '{default: '0};
            cur_q     <= '{default: '0};
            pwm_q     <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cur_q     <= cur_d;
            pwm_q     <= pwm_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    assign pwm_val = pwm_q;
    assign busy    = (state_q == SCAN);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_led_fade_engine.sv
// Directed self-checking bench for led_fade_engine; honours FADE_EXP_CURVE_EN for expected PWM levels.
module tb_led_fade_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [7:0]  wr_data;
    logic [3:0]  rate;
    logic        frame_tick;
    logic [63:0] pwm_val;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int bc;

    logic [7:0] fade_exp [8] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3};
    logic [7:0] curve_in [3] = '{8'h20, 8'h3F, 8'hFF};

    led_fade_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .rate       (rate),
        .frame_tick (frame_tick),
        .pwm_val    (pwm_val),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_map(input logic [7:0] v);
`ifdef FADE_EXP_CURVE_EN
        int m, e;
        if (v == 8'd0) return 8'd0;
        m = 32 + (int'(v) % 32);
        e = int'(v) / 32;
        return 8'((m * (1 << e)) / 32);
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic write(input logic [2:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic tick_pulse();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // One frame_tick, then count busy cycles over the following 12 cycles.
    task automatic tick(output int cnt);
        tick_pulse();
        cnt = 0;
        repeat (12) begin
            if (busy) cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0; rate = '0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_pwm", pwm_val, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ovr", 64'(overrun), 64'd0);

        // Instant mode: two-cycle write-to-output latency
        write(3'd3, 8'h80);
        @(posedge clk); #1;
        check("inst_lat1", 64'(pwm_val[31:24]), 64'd0);
        @(posedge clk); #1;
        check("inst_ch3", 64'(pwm_val[31:24]), 64'(exp_map(8'h80)));
        check("inst_others", {pwm_val[63:32], pwm_val[23:0]}, 64'd0);
        @(negedge clk);
        write(3'd3, 8'h00);
        repeat (3) @(negedge clk);

        // rate=2 fade of ch0 toward 3
        rate = 4'd2;
        write(3'd0, 8'd3);
        for (int t = 0; t < 8; t++) begin
            tick(bc);
            check("fade_busy", 64'(bc), (t % 2 == 1) ? 64'd8 : 64'd0);
            check("fade_cur0", 64'(pwm_val[7:0]), 64'(exp_map(fade_exp[t])));
        end
        check("zero_ch5", 64'(pwm_val[47:40]), 64'd0);

        // ch5 saturation at 255 and floor at 0
        rate = 4'd1;
        write(3'd5, 8'hFF);
        repeat (260) tick(bc);
        check("sat_ch5", 64'(pwm_val[47:40]), 64'(exp_map(8'hFF)));
        check("sat_ch0", 64'(pwm_val[7:0]), 64'(exp_map(8'd3)));
        write(3'd5, 8'h00);
        repeat (260) tick(bc);
        check("floor_ch5", 64'(pwm_val[47:40]), 64'd0);

        // Write to ch2 in the cycle its step is processed uses the old target
        tick_pulse();
        repeat (2) @(negedge clk);
        write(3'd2, 8'd5);
        repeat (12) @(negedge clk);
        check("samecyc_pass1", 64'(pwm_val[23:16]), 64'd0);
        tick(bc);
        check("samecyc_pass2", 64'(pwm_val[23:16]), 64'(exp_map(8'd1)));

        // Step during SCAN is dropped and flags overrun
        check("ovr_before", 64'(overrun), 64'd0);
        write(3'd1, 8'd10);
        tick_pulse();
        repeat (2) @(negedge clk);
        tick_pulse();
        check("ovr_set", 64'(overrun), 64'd1);
        check("ovr_busy", 64'(busy), 64'd1);
        repeat (12) @(negedge clk);
        check("ovr_idle", 64'(busy), 64'd0);
        check("ovr_ch1", 64'(pwm_val[15:8]), 64'(exp_map(8'd1)));
        repeat (30) @(negedge clk);
        check("ovr_sticky", 64'(overrun), 64'd1);

        // Level mapping through instant writes
        rate = 4'd0;
        for (int k = 0; k < 3; k++) begin
            write(3'd6, curve_in[k]);
            @(posedge clk); @(posedge clk); #1;
            check("map_ch6", 64'(pwm_val[55:48]), 64'(exp_map(curve_in[k])));
            @(negedge clk);
        end

        // Reset in the middle of a scan pass
        rate = 4'd1;
        write(3'd6, 8'h00);
        tick_pulse();
        repeat (2) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_pwm", pwm_val, 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_ovr", 64'(overrun), 64'd0);
        @(negedge clk);
        rate = 4'd0;
        write(3'd7, 8'h55);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_wr_ignored", pwm_val, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
